// File: rtl/bpsk_carrier_mod.sv
// BPSK carrier synthesiser: NCO phase accumulator, sine ROM, ramped envelope, 3-stage sample pipeline.
// Define BPSK_IQ_OUT_EN to add the quadrature (cosine) output port sample_q.
module bpsk_carrier_mod #(
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int RAMP_LEN_LOG2 = 6,
  parameter logic [PHASE_WIDTH-1:0] FCW_RESET = 32'h0400_0000
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    gen_en,
  input  logic                    phase_ctrl,
  input  logic [PHASE_WIDTH-1:0]  fcw,
  input  logic                    fcw_load,
  input  logic [15:0]             amp,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic [15:0]             flip_cnt
`ifdef BPSK_IQ_OUT_EN
  ,
  output logic [SAMPLE_WIDTH-1:0] sample_q
`endif
);

  localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam int EW = RAMP_LEN_LOG2 + 1;
  localparam int GW = 16 + EW;
  localparam logic [EW-1:0] ENV_MAX = {1'b1, {RAMP_LEN_LOG2{1'b0}}};
  localparam logic [EW-1:0] ENV_TOP = {1'b0, {RAMP_LEN_LOG2{1'b1}}};
  localparam logic [EW-1:0] ENV_ONE = EW'(1);
  localparam logic [LUT_ADDR_WIDTH-1:0] HALF_TURN = {1'b1, {(LUT_ADDR_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

  state_t                   state_q;
  logic [PHASE_WIDTH-1:0]   acc_q;
  logic [PHASE_WIDTH-1:0]   fcw_q;
  logic [EW-1:0]            env_q;
  logic                     busy_q;
  logic                     pc_q;
  logic                     pc_prev_q;
  logic [15:0]              flip_cnt_q;

  logic [LUT_ADDR_WIDTH-1:0] addr_d;
  logic [LUT_ADDR_WIDTH-1:0] addr_q;
  logic [GW-1:0]             gain_full_d;
  logic [15:0]               gain1_q;
  logic [15:0]               gain2_q;
  logic signed [15:0]        lut_q;
  logic signed [32:0]        prod_d;
  logic [2:0]                valid_q;
  logic [SAMPLE_WIDTH-1:0]   sample_out_q;

  // Full-wave sine ROM, round(32767*sin(2*pi*k/N)), built at elaboration.
  logic signed [15:0] lut_rom [LUT_DEPTH];
  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
    localparam real ANGLE = 2.0 * 3.14159265358979323846 * $itor(gi) / $itor(LUT_DEPTH);
    localparam real VALUE = 32767.0 * $sin(ANGLE);
    localparam int ROUNDED = (VALUE >= 0.0) ? $rtoi(VALUE + 0.5) : -$rtoi(0.5 - VALUE);
    assign lut_rom[gi] = 16'(ROUNDED);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      fcw_q      <= FCW_RESET;
      env_q      <= '0;
      busy_q     <= 1'b0;
      pc_q       <= 1'b0;
      pc_prev_q  <= 1'b0;
      flip_cnt_q <= '0;
    end else begin
      pc_q      <= phase_ctrl;
      pc_prev_q <= pc_q;
      if (state_q == ACTIVE && pc_q != pc_prev_q) flip_cnt_q <= flip_cnt_q + 16'd1;
      case (state_q)
        IDLE: begin
          acc_q <= '0;
          if (fcw_load) fcw_q <= fcw;
          if (gen_en) begin
            state_q <= RAMP_UP;
            env_q   <= ENV_ONE;
            busy_q  <= 1'b1;
          end
        end
        RAMP_UP: begin
          acc_q <= acc_q + fcw_q;
          if (!gen_en) begin
            state_q <= RAMP_DOWN;
          end else begin
            env_q <= env_q + ENV_ONE;
            if (env_q == ENV_TOP) state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          acc_q <= acc_q + fcw_q;
          if (!gen_en) state_q <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (gen_en) begin
            // A reversal straight out of ACTIVE leaves env at max, so resume ACTIVE directly.
            acc_q   <= acc_q + fcw_q;
            state_q <= (env_q == ENV_MAX) ? ACTIVE : RAMP_UP;
          end else if (env_q <= ENV_ONE) begin
            state_q <= IDLE;
            acc_q   <= '0;
            env_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_q + fcw_q;
            env_q <= env_q - ENV_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d      = acc_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH] + (pc_q ? HALF_TURN : '0);
    gain_full_d = {{EW{1'b0}}, amp} * {{16{1'b0}}, env_q};
    prod_d      = $signed({{17{lut_q[15]}}, lut_q}) * $signed({17'd0, gain2_q});
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_q       <= '0;
      gain1_q      <= '0;
      lut_q        <= '0;
      gain2_q      <= '0;
      valid_q      <= '0;
      sample_out_q <= '0;
    end else begin
      addr_q       <= addr_d;
      gain1_q      <= 16'(gain_full_d >> RAMP_LEN_LOG2);
      lut_q        <= lut_rom[addr_q];
      gain2_q      <= gain1_q;
      valid_q      <= {valid_q[1:0], busy_q};
      sample_out_q <= valid_q[1] ? SAMPLE_WIDTH'(prod_d >>> 16) : '0;
    end
  end

`ifdef BPSK_IQ_OUT_EN
  localparam logic [LUT_ADDR_WIDTH-1:0] QUARTER_TURN = {2'b01, {(LUT_ADDR_WIDTH-2){1'b0}}};

  logic [LUT_ADDR_WIDTH-1:0] addr_c_q;
  logic signed [15:0]        lut_c_q;
  logic signed [32:0]        prod_c_d;
  logic [SAMPLE_WIDTH-1:0]   sample_q_q;

  always_comb begin
    prod_c_d = $signed({{17{lut_c_q[15]}}, lut_c_q}) * $signed({17'd0, gain2_q});
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_c_q   <= '0;
      lut_c_q    <= '0;
      sample_q_q <= '0;
    end else begin
      addr_c_q   <= addr_d + QUARTER_TURN;
      lut_c_q    <= lut_rom[addr_c_q];
      sample_q_q <= valid_q[1] ? SAMPLE_WIDTH'(prod_c_d >>> 16) : '0;
    end
  end

  assign sample_q = sample_q_q;
`endif

  assign sample_out   = sample_out_q;
  assign sample_valid = valid_q[2];
  assign busy         = busy_q;
  assign flip_cnt     = flip_cnt_q;

endmodule

// File: tb/tb_bpsk_carrier_mod.sv
// Bench for bpsk_carrier_mod: directed literal checks plus random stimulus against a
// cycle-level behavioural model (envelope level, burst sample count, sine math).
module tb_bpsk_carrier_mod;

  localparam logic [31:0] FCW_RESET = 32'h0400_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        gen_en;
  logic        phase_ctrl;
  logic [31:0] fcw;
  logic        fcw_load;
  logic [15:0] amp;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic [15:0] flip_cnt;
`ifdef BPSK_IQ_OUT_EN
  logic [15:0] sample_q;
`endif

  always #5 clk = ~clk;

  bpsk_carrier_mod dut (
    .clk          (clk),
    .nrst         (nrst),
    .gen_en       (gen_en),
    .phase_ctrl   (phase_ctrl),
    .fcw          (fcw),
    .fcw_load     (fcw_load),
    .amp          (amp),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .flip_cnt     (flip_cnt)
`ifdef BPSK_IQ_OUT_EN
    , .sample_q   (sample_q)
`endif
  );

  int n_checks = 0;
  int n_err = 0;

  int seq4[4]  = '{0, 32766, 0, -32767};
  int flip4[4] = '{0, -32767, 0, 32766};
  int seq8[8]  = '{0, 23169, 32766, 23169, 0, -23170, -32767, -23170};

  // Behavioural model: envelope level, direction of travel, samples since burst start.
  bit          m_busy, m_up, m_pc, m_pcprev;
  int          m_env, m_flip;
  longint      m_n;
  logic [31:0] m_fcw;
  longint      q1, q2, q3, c1, c2, c3;
  bit          v1, v2, v3;

  function automatic int lut(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] acc;
    int k, g;
    longint x, xc;
    if (!nrst) begin
      m_busy = 0; m_up = 0; m_env = 0; m_n = 0; m_fcw = FCW_RESET;
      m_pc = 0; m_pcprev = 0; m_flip = 0;
      q1 = 0; q2 = 0; q3 = 0; c1 = 0; c2 = 0; c3 = 0;
      v1 = 0; v2 = 0; v3 = 0;
      return;
    end
    acc = 32'(m_n * longint'(m_fcw));
    k   = (int'(acc[31:24]) + (m_pc ? 128 : 0)) % 256;
    g   = (int'(amp) * m_env) >>> 6;
    x   = m_busy ? ((longint'(lut(k)) * g) >>> 16) : 0;
    xc  = m_busy ? ((longint'(lut((k + 64) % 256)) * g) >>> 16) : 0;
    q3 = q2; q2 = q1; q1 = x;
    c3 = c2; c2 = c1; c1 = xc;
    v3 = v2; v2 = v1; v1 = m_busy;
    if (m_busy && m_up && m_env == 64 && m_pc != m_pcprev) m_flip = (m_flip + 1) % 65536;
    m_pcprev = m_pc;
    m_pc = phase_ctrl;
    if (!m_busy) begin
      if (fcw_load) m_fcw = fcw;
      m_n = 0;
      if (gen_en) begin m_busy = 1; m_up = 1; m_env = 1; end
    end else begin
      m_n++;
      if (gen_en != m_up) m_up = gen_en;
      else if (gen_en) m_env = (m_env < 64) ? m_env + 1 : 64;
      else if (m_env <= 1) begin m_busy = 0; m_env = 0; m_n = 0; end
      else m_env--;
    end
  endtask

  task automatic compare_all();
    check("sample_out", longint'($signed(sample_out)), q3);
    check("sample_valid", sample_valid, v3);
    check("busy", busy, m_busy);
    check("flip_cnt", flip_cnt, m_flip);
`ifdef BPSK_IQ_OUT_EN
    check("sample_q", longint'($signed(sample_q)), c3);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, w, maxv, minv;
    nrst = 0; gen_en = 1; phase_ctrl = 0; fcw = '0; fcw_load = 0; amp = 16'hFFFF;
    repeat (4) tick();
    check("reset_sample", sample_out, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_flip", flip_cnt, 0);

    // Carrier at fs/4, then a phase reversal while ACTIVE
    nrst = 1; gen_en = 0; fcw = 32'h4000_0000; fcw_load = 1;
    tick();
    fcw_load = 0; gen_en = 1;
    for (int t = 0; t <= 80; t++) begin
      if (t == 72) phase_ctrl = 1;
      tick();
      s = int'($signed(sample_out));
      if (t == 0) check("busy_rise", busy, 1);
      if (t == 2) check("valid_early", sample_valid, 0);
      if (t == 3) check("valid_rise", sample_valid, 1);
      if (t >= 68 && t <= 71) check("carrier0", s, seq4[(t - 3) % 4]);
      if (t >= 75 && t <= 78) check("carrier180", s, flip4[(t - 3) % 4]);
    end
    check("flip_cnt_one", flip_cnt, 1);

    // fcw_load mid-burst must not change the period
    fcw = 32'h2000_0000; fcw_load = 1;
    for (int t = 81; t <= 89; t++) begin
      tick();
      fcw_load = 0;
      s = int'($signed(sample_out));
      if (t >= 85 && t <= 88) check("fcw_ignored", s, flip4[(t - 3) % 4]);
    end
    gen_en = 0;
    w = 0;
    while (busy && w < 300) begin tick(); w++; end
    check("ramp_down_done", busy, 0);
    repeat (3) tick();
    check("idle_valid", sample_valid, 0);
    check("idle_sample", sample_out, 0);

    // Reload in IDLE: period becomes 8 samples
    fcw_load = 1; phase_ctrl = 0;
    tick();
    fcw_load = 0; gen_en = 1;
    for (int t = 0; t <= 80; t++) begin
      tick();
      s = int'($signed(sample_out));
      if (t >= 70 && t <= 77) check("carrier_p8", s, seq8[(t - 3) % 8]);
    end

    // Second reversal, then reset in the middle of the burst
    phase_ctrl = 1;
    repeat (5) tick();
    check("flip_cnt_two", flip_cnt, 2);
    nrst = 0;
    tick();
    check("mid_reset_sample", sample_out, 0);
    check("mid_reset_valid", sample_valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_flip", flip_cnt, 0);

    // Short burst: gen_en high for 20 clk, then released
    nrst = 1; gen_en = 0; phase_ctrl = 0; fcw = 32'h4000_0000; fcw_load = 1;
    tick();
    fcw_load = 0;
    maxv = 0; minv = 0;
    for (int t = 0; t <= 50; t++) begin
      gen_en = (t < 20);
      tick();
      s = int'($signed(sample_out));
      if (s > maxv) maxv = s;
      if (s < minv) minv = s;
      if (t == 39) check("abort_busy_hold", busy, 1);
      if (t == 40) check("abort_busy_fall", busy, 0);
      if (t == 42) check("abort_valid_hold", sample_valid, 1);
      if (t == 43) check("abort_valid_fall", sample_valid, 0);
    end
    check("abort_peak_neg", minv, -10240);
    n_checks++;
    if (maxv > 10239) begin
      n_err++;
      $display("FAIL abort_peak_pos: got %0d expected at most 10239", maxv);
    end

    // Random traffic: long holds first, then frequent reversals
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range((i < 2000) ? 99 : 11, 0) == 0) gen_en = ~gen_en;
      if ($urandom_range(7, 0) == 0) phase_ctrl = ~phase_ctrl;
      fcw_load = ($urandom_range(9, 0) == 0);
      if (fcw_load) fcw = $urandom();
      if ($urandom_range(49, 0) == 0) amp = 16'($urandom());
      nrst = ($urandom_range(599, 0) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
